// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the two-source bus arbiter: FSM state codes and source IDs.
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN1 = 2'd1;
  localparam logic [1:0] ST_OWN2 = 2'd2;

  // A single bit is enough to record which source was served last.
  localparam logic SRC1 = 1'b0;
  localparam logic SRC2 = 1'b1;

endpackage

// File: rtl/burst_counter.sv
// Per-grant transfer counter; wraps to zero on the terminal count, or when cleared.
module burst_counter
  import bus_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign tc  = (cnt_q == TC_VAL);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a two-source shared bus with bounded bursts and direct handover.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic             req2,
  output logic             select,
  output logic             grant1,
  output logic             grant2,
  output logic             xfer1,
  output logic             xfer2,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             busy
);

  logic [1:0] state_d, state_q;
  logic       last_d, last_q;
  logic       select_d, select_q;
  logic       grant1_q, grant2_q;
  logic       cnt_clr;
  logic       cnt_tc;

  assign xfer1  = grant1_q & req1;
  assign xfer2  = grant2_q & req2;
  assign select = select_q;
  assign grant1 = grant1_q;
  assign grant2 = grant2_q;
  assign busy   = grant1_q | grant2_q;

  burst_counter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_burst_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (xfer1 | xfer2),
    .clr   (cnt_clr),
    .cnt   (burst_cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Under contention the source not served last wins.
        if (req1 && (!req2 || last_q == SRC2)) begin
          state_d = ST_OWN1;
        end else if (req2) begin
          state_d = ST_OWN2;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_d = req2 ? ST_OWN2 : ST_IDLE;
          last_d  = SRC1;
          cnt_clr = 1'b1;
        end else if (cnt_tc && req2) begin
          state_d = ST_OWN2;
          last_d  = SRC1;
        end
      end
      ST_OWN2: begin
        if (!req2) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
          last_d  = SRC2;
          cnt_clr = 1'b1;
        end else if (cnt_tc && req1) begin
          state_d = ST_OWN1;
          last_d  = SRC2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select moves with the grants; in IDLE it holds so the buffer enables stay put.
  always_comb begin
    select_d = select_q;
    if (state_d == ST_OWN1) begin
      select_d = 1'b0;
    end else if (state_d == ST_OWN2) begin
      select_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= SRC2;
      select_q <= 1'b0;
      grant1_q <= 1'b0;
      grant2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      select_q <= select_d;
      grant1_q <= (state_d == ST_OWN1);
      grant2_q <= (state_d == ST_OWN2);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (BURST_LEN=4): reset, single source, contention, bursts, handover.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1;
  logic       req2;
  logic       select;
  logic       grant1;
  logic       grant2;
  logic       xfer1;
  logic       xfer2;
  logic [3:0] burst_cnt;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic saw_both_grants = 1'b0;
  logic saw_bad_select  = 1'b0;
  logic saw_both_xfer   = 1'b0;

  bus_arbiter #(
    .BURST_LEN (4),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req1      (req1),
    .req2      (req2),
    .select    (select),
    .grant1    (grant1),
    .grant2    (grant2),
    .xfer1     (xfer1),
    .xfer2     (xfer2),
    .burst_cnt (burst_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (grant1 && grant2) saw_both_grants = 1'b1;
    if ((grant2 && !select) || (grant1 && select)) saw_bad_select = 1'b1;
    if (xfer1 && xfer2) saw_both_xfer = 1'b1;
  end

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cyc();
    reset = 1'b1;
    req1  = 1'b0;
    req2  = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    req1  = 1'b1;
    req2  = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    total++;
    if ({select, grant1, grant2, burst_cnt} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: sel/g1/g2/cnt=%b required 0000000", {select, grant1, grant2, burst_cnt});
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (grant1 !== 1'b0 || busy !== 1'b0 || xfer1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: g1=%b busy=%b x1=%b required 0 0 0", grant1, busy, xfer1);
    end
    cyc();
    @(negedge clk);
    total++;
    if (grant1 !== 1'b1 || grant2 !== 1'b0 || select !== 1'b0 || xfer1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_win: g1=%b g2=%b sel=%b x1=%b required 1 0 0 1", grant1, grant2, select, xfer1);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cyc();
    req2 = 1'b1;
    @(negedge clk);
    total++;
    if (grant2 !== 1'b0 || xfer2 !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: g2=%b x2=%b required 0 0", grant2, xfer2);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      total++;
      if (grant2 !== 1'b1 || select !== 1'b1 || xfer2 !== 1'b1 || xfer1 !== 1'b0 || burst_cnt !== 4'(k)) begin
        bad++;
        $display("FAIL single_xfer[%0d]: g2=%b sel=%b x2=%b x1=%b cnt=%0d required 1 1 1 0 %0d",
                 k, grant2, select, xfer2, xfer1, burst_cnt, k);
      end
    end
    cyc();
    req2 = 1'b0;
    @(negedge clk);
    total++;
    if (xfer2 !== 1'b0 || grant2 !== 1'b1) begin
      bad++;
      $display("FAIL single_drop: x2=%b g2=%b required 0 1", xfer2, grant2);
    end
    cyc();
    @(negedge clk);
    total++;
    if (grant2 !== 1'b0 || busy !== 1'b0 || select !== 1'b1 || burst_cnt !== 4'd0) begin
      bad++;
      $display("FAIL single_idle_hold: g2=%b busy=%b sel=%b cnt=%0d required 0 0 1 0", grant2, busy, select, burst_cnt);
    end
  endtask

  task automatic test_contention();
    logic       exp_sel;
    logic [3:0] exp_cnt;
    apply_reset();
    cyc();
    req1 = 1'b1;
    req2 = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      @(negedge clk);
      exp_sel = ((k - 1) / 4) % 2 == 1;
      exp_cnt = 4'((k - 1) % 4);
      total++;
      if (select !== exp_sel || xfer1 !== !exp_sel || xfer2 !== exp_sel || burst_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL contention[%0d]: sel=%b x1=%b x2=%b cnt=%0d required %b %b %b %0d",
                 k, select, xfer1, xfer2, burst_cnt, exp_sel, !exp_sel, exp_sel, exp_cnt);
      end
    end
  endtask

  task automatic test_lone_burst();
    apply_reset();
    cyc();
    req1 = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      @(negedge clk);
      total++;
      if (grant1 !== 1'b1 || xfer1 !== 1'b1 || select !== 1'b0 || burst_cnt !== 4'((k - 1) % 4)) begin
        bad++;
        $display("FAIL lone_burst[%0d]: g1=%b x1=%b sel=%b cnt=%0d required 1 1 0 %0d",
                 k, grant1, xfer1, select, burst_cnt, (k - 1) % 4);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    cyc();
    req1 = 1'b1;
    cyc();
    cyc();
    req1 = 1'b0;
    req2 = 1'b1;
    @(negedge clk);
    total++;
    if (grant1 !== 1'b1 || burst_cnt !== 4'd1 || xfer1 !== 1'b0) begin
      bad++;
      $display("FAIL early_pre: g1=%b cnt=%0d x1=%b required 1 1 0", grant1, burst_cnt, xfer1);
    end
    cyc();
    req1 = 1'b1;
    @(negedge clk);
    total++;
    if (grant2 !== 1'b1 || grant1 !== 1'b0 || select !== 1'b1 || burst_cnt !== 4'd0 || dut.last_q !== 1'b0) begin
      bad++;
      $display("FAIL early_handover: g2=%b g1=%b sel=%b cnt=%0d last=%b required 1 0 1 0 0",
               grant2, grant1, select, burst_cnt, dut.last_q);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      total++;
      if (k < 4 && (xfer2 !== 1'b1 || burst_cnt !== 4'(k))) begin
        bad++;
        $display("FAIL early_resume[%0d]: x2=%b cnt=%0d required 1 %0d", k, xfer2, burst_cnt, k);
      end else if (k == 4 && (xfer1 !== 1'b1 || select !== 1'b0 || burst_cnt !== 4'd0)) begin
        bad++;
        $display("FAIL early_back_to_1: x1=%b sel=%b cnt=%0d required 1 0 0", xfer1, select, burst_cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    cyc();
    req2 = 1'b1;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (grant2 !== 1'b1 || burst_cnt !== 4'd2) begin
      bad++;
      $display("FAIL mid_reset_pre: g2=%b cnt=%0d required 1 2", grant2, burst_cnt);
    end
    cyc();
    reset = 1'b0;
    req2  = 1'b0;
    @(negedge clk);
    total++;
    if ({select, grant1, grant2, busy, burst_cnt} !== 8'b0) begin
      bad++;
      $display("FAIL mid_reset_post: sel/g1/g2/busy/cnt=%b required 00000000", {select, grant1, grant2, busy, burst_cnt});
    end
  endtask

  task automatic test_invariants();
    total++;
    if ({saw_both_grants, saw_bad_select, saw_both_xfer} !== 3'b000) begin
      bad++;
      $display("FAIL invariants: both_grants/bad_select/both_xfer=%b required 000",
               {saw_both_grants, saw_bad_select, saw_both_xfer});
    end
  endtask

  initial begin
    reset = 1'b1;
    req1  = 1'b0;
    req2  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_lone_burst();
    test_early_release();
    test_mid_reset();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
